// File: rtl/mem_stage_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_buf_if
// Description : EX -> MEM stage bundle. Carries the EX-side valid/ready
//               handshake with its payload, the flush and misalignment
//               qualifiers, the MEM-side valid/ready handshake with its
//               payload, and the buffer occupancy.
//   slave  modport : view of the stage buffer (consumes EX, produces MEM)
//   master modport : view of the environment driving EX and sinking MEM
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_buf_if #(
  parameter int WORD_ADDR_W = 30,
  parameter int WORD_DATA_W = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int CTRL_OP_W   = 2,
  parameter int EXP_W       = 3
);
  // EX side
  logic                   flush;
  logic                   miss_align;
  logic                   in_valid;
  logic                   in_ready;
  logic [WORD_ADDR_W-1:0] in_pc;
  logic                   in_en;
  logic                   in_br_flag;
  logic [CTRL_OP_W-1:0]   in_ctrl_op;
  logic [REG_ADDR_W-1:0]  in_dst_addr;
  logic                   in_gpr_we_;
  logic [EXP_W-1:0]       in_exp_code;
  logic [WORD_DATA_W-1:0] in_out;
  // MEM side
  logic                   out_valid;
  logic                   out_ready;
  logic [WORD_ADDR_W-1:0] out_pc;
  logic                   out_en;
  logic                   out_br_flag;
  logic [CTRL_OP_W-1:0]   out_ctrl_op;
  logic [REG_ADDR_W-1:0]  out_dst_addr;
  logic                   out_gpr_we_;
  logic [EXP_W-1:0]       out_exp_code;
  logic [WORD_DATA_W-1:0] out_out;
  logic [1:0]             occupancy;

  modport slave (
    input  flush, miss_align, in_valid, in_pc, in_en, in_br_flag, in_ctrl_op,
           in_dst_addr, in_gpr_we_, in_exp_code, in_out, out_ready,
    output in_ready, out_valid, out_pc, out_en, out_br_flag, out_ctrl_op,
           out_dst_addr, out_gpr_we_, out_exp_code, out_out, occupancy
  );

  modport master (
    output flush, miss_align, in_valid, in_pc, in_en, in_br_flag, in_ctrl_op,
           in_dst_addr, in_gpr_we_, in_exp_code, in_out, out_ready,
    input  in_ready, out_valid, out_pc, out_en, out_br_flag, out_ctrl_op,
           out_dst_addr, out_gpr_we_, out_exp_code, out_out, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_buf
// Description : EX/MEM pipeline buffer with valid/ready handshake. With
//               SKID=1 it is a two-entry skid buffer (main M, skid S) whose
//               in_ready is a pure register output; with SKID=0 it is a
//               single register with a combinational in_ready. Misaligned
//               accesses are converted into a bubble carrying the
//               misalignment exception code. Flush drops all entries and
//               the word presented in the flush cycle.
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high
//   bus   : mem_stage_buf_if.slave (EX handshake/payload, flush,
//           miss_align, MEM handshake/payload, occupancy)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_buf #(
  parameter int WORD_ADDR_W    = 30,
  parameter int WORD_DATA_W    = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int CTRL_OP_W      = 2,
  parameter int EXP_W          = 3,
  parameter int CTRL_OP_NOP    = 0,
  parameter int EXP_NO_EXP     = 0,
  parameter int EXP_MISS_ALIGN = 4,
  parameter int SKID           = 1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  mem_stage_buf_if.slave   bus
);

  // Packed payload: {pc, en, br_flag, ctrl_op, dst_addr, gpr_we_, exp_code, out}
  localparam int PW = WORD_ADDR_W + 1 + 1 + CTRL_OP_W + REG_ADDR_W + 1
                    + EXP_W + WORD_DATA_W;

  localparam logic [PW-1:0] C_BUBBLE = {
    {WORD_ADDR_W{1'b0}}, 1'b0, 1'b0, CTRL_OP_W'(CTRL_OP_NOP),
    {REG_ADDR_W{1'b0}}, 1'b1, EXP_W'(EXP_NO_EXP), {WORD_DATA_W{1'b0}}
  };

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  logic [PW-1:0] w_cap;
  logic [PW-1:0] w_m_pl;
  logic          w_m_valid;
  logic          w_in_ready;
  logic [1:0]    w_occ;
  logic          w_in_xfer;
  logic          w_out_xfer;

  // A misaligned access keeps its PC/enable/delay-slot info so the exception
  // can be attributed, but must not write a register or carry a result.
  always_comb begin
    w_cap = {bus.in_pc, bus.in_en, bus.in_br_flag, bus.in_ctrl_op,
             bus.in_dst_addr, bus.in_gpr_we_, bus.in_exp_code, bus.in_out};
    if (bus.miss_align) begin
      w_cap = {bus.in_pc, bus.in_en, bus.in_br_flag, CTRL_OP_W'(CTRL_OP_NOP),
               {REG_ADDR_W{1'b0}}, 1'b1, EXP_W'(EXP_MISS_ALIGN),
               {WORD_DATA_W{1'b0}}};
    end
  end

  assign w_in_xfer  = bus.in_valid & w_in_ready;
  assign w_out_xfer = w_m_valid & bus.out_ready;

  generate
    if (SKID != 0) begin : g_skid
      state_t        r_state;
      logic          r_m_valid;
      logic [PW-1:0] r_m_pl;
      logic          r_s_valid;
      logic [PW-1:0] r_s_pl;

      always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
          // Flush drops the input of its own cycle too, so it shares the
          // reset path; any concurrent output transfer was already taken.
          r_state   <= ST_EMPTY;
          r_m_valid <= 1'b0;
          r_m_pl    <= C_BUBBLE;
          r_s_valid <= 1'b0;
          r_s_pl    <= C_BUBBLE;
        end else begin
          case (r_state)
            ST_EMPTY: begin
              if (w_in_xfer) begin
                r_m_pl    <= w_cap;
                r_m_valid <= 1'b1;
                r_state   <= ST_ONE;
              end
            end
            ST_ONE: begin
              if (w_in_xfer && w_out_xfer) begin
                r_m_pl <= w_cap;
              end else if (w_out_xfer) begin
                r_m_pl    <= C_BUBBLE;
                r_m_valid <= 1'b0;
                r_state   <= ST_EMPTY;
              end else if (w_in_xfer) begin
                // MEM stalled: park the new word in S, M stays stable.
                r_s_pl    <= w_cap;
                r_s_valid <= 1'b1;
                r_state   <= ST_TWO;
              end
            end
            ST_TWO: begin
              if (w_out_xfer) begin
                r_m_pl    <= r_s_pl;
                r_s_pl    <= C_BUBBLE;
                r_s_valid <= 1'b0;
                r_state   <= ST_ONE;
              end
            end
            default: begin
              r_state   <= ST_EMPTY;
              r_m_valid <= 1'b0;
              r_m_pl    <= C_BUBBLE;
              r_s_valid <= 1'b0;
              r_s_pl    <= C_BUBBLE;
            end
          endcase
        end
      end

      // Ready depends only on state, breaking the ready path from MEM.
      assign w_in_ready = ~r_s_valid;
      assign w_m_valid  = r_m_valid;
      assign w_m_pl     = r_m_pl;
      assign w_occ      = r_state;
    end else begin : g_single
      logic          r_m_valid;
      logic [PW-1:0] r_m_pl;

      always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
          r_m_valid <= 1'b0;
          r_m_pl    <= C_BUBBLE;
        end else if (w_in_xfer) begin
          r_m_valid <= 1'b1;
          r_m_pl    <= w_cap;
        end else if (w_out_xfer) begin
          r_m_valid <= 1'b0;
          r_m_pl    <= C_BUBBLE;
        end
      end

      // Pop and reload in the same cycle keeps full throughput.
      assign w_in_ready = ~r_m_valid | bus.out_ready;
      assign w_m_valid  = r_m_valid;
      assign w_m_pl     = r_m_pl;
      assign w_occ      = {1'b0, r_m_valid};
    end
  endgenerate

  // M always holds bubble values while invalid, so the payload needs no mask.
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_m_valid;
  assign bus.occupancy = w_occ;
  assign {bus.out_pc, bus.out_en, bus.out_br_flag, bus.out_ctrl_op,
          bus.out_dst_addr, bus.out_gpr_we_, bus.out_exp_code,
          bus.out_out} = w_m_pl;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_buf
// Description : Directed self-checking bench for mem_stage_buf. Instance
//               dut_a uses the two-entry skid buffer, dut_b the single
//               register variant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_buf;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  mem_stage_buf_if #(.WORD_ADDR_W(30), .WORD_DATA_W(32), .REG_ADDR_W(5),
                     .CTRL_OP_W(2), .EXP_W(3)) bus_a ();
  mem_stage_buf_if #(.WORD_ADDR_W(30), .WORD_DATA_W(32), .REG_ADDR_W(5),
                     .CTRL_OP_W(2), .EXP_W(3)) bus_b ();

  mem_stage_buf #(.SKID(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  mem_stage_buf #(.SKID(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are examined 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;

    // ---------------- reset with in_valid held high ----------------------
    reset = 1'b1;
    bus_a.flush = 1'b0; bus_a.miss_align = 1'b0; bus_a.in_valid = 1'b1;
    bus_a.in_pc = 30'h100; bus_a.in_en = 1'b1; bus_a.in_br_flag = 1'b0;
    bus_a.in_ctrl_op = 2'd0; bus_a.in_dst_addr = 5'd0; bus_a.in_gpr_we_ = 1'b1;
    bus_a.in_exp_code = 3'd0; bus_a.in_out = 32'h0; bus_a.out_ready = 1'b0;
    bus_b.flush = 1'b0; bus_b.miss_align = 1'b0; bus_b.in_valid = 1'b0;
    bus_b.in_pc = 30'h0; bus_b.in_en = 1'b0; bus_b.in_br_flag = 1'b0;
    bus_b.in_ctrl_op = 2'd0; bus_b.in_dst_addr = 5'd0; bus_b.in_gpr_we_ = 1'b1;
    bus_b.in_exp_code = 3'd0; bus_b.in_out = 32'h0; bus_b.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("rst_occ", 64'(bus_a.occupancy), 64'd0);
    chk("rst_gpr_we_", 64'(bus_a.out_gpr_we_), 64'd1);
    chk("rst_out_pc", 64'(bus_a.out_pc), 64'd0);
    reset = 1'b0;
    chk("post_rst_in_ready", 64'(bus_a.in_ready), 64'd1);
    tick();
    chk("first_valid", 64'(bus_a.out_valid), 64'd1);
    chk("first_pc", 64'(bus_a.out_pc), 64'h100);
    chk("first_occ", 64'(bus_a.occupancy), 64'd1);
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    tick();
    chk("pop_empty_valid", 64'(bus_a.out_valid), 64'd0);
    chk("pop_empty_pc_bubble", 64'(bus_a.out_pc), 64'd0);
    chk("pop_empty_en_bubble", 64'(bus_a.out_en), 64'd0);

    // ---------------- streaming at full rate ------------------------------
    bus_a.in_valid = 1'b1; bus_a.in_pc = 30'h10; bus_a.in_ctrl_op = 2'd1;
    bus_a.in_dst_addr = 5'd5; bus_a.in_gpr_we_ = 1'b0; bus_a.in_exp_code = 3'd2;
    bus_a.in_out = 32'hCAFE;
    tick();
    chk("s0_pc", 64'(bus_a.out_pc), 64'h10);
    chk("s0_ctrl", 64'(bus_a.out_ctrl_op), 64'd1);
    chk("s0_dst", 64'(bus_a.out_dst_addr), 64'd5);
    chk("s0_we_", 64'(bus_a.out_gpr_we_), 64'd0);
    chk("s0_exp", 64'(bus_a.out_exp_code), 64'd2);
    chk("s0_out", 64'(bus_a.out_out), 64'hCAFE);
    bus_a.in_pc = 30'h11; bus_a.in_exp_code = 3'd0;
    tick();
    chk("s1_pc", 64'(bus_a.out_pc), 64'h11);
    chk("s1_occ", 64'(bus_a.occupancy), 64'd1);
    bus_a.in_pc = 30'h12;
    tick();
    chk("s2_pc", 64'(bus_a.out_pc), 64'h12);
    chk("s2_occ", 64'(bus_a.occupancy), 64'd1);
    bus_a.in_valid = 1'b0;
    tick();
    chk("s_drain_valid", 64'(bus_a.out_valid), 64'd0);

    // ---------------- skid: fill both entries under stall -----------------
    bus_a.out_ready = 1'b0; bus_a.in_valid = 1'b1; bus_a.in_pc = 30'h20;
    tick();
    chk("k0_pc", 64'(bus_a.out_pc), 64'h20);
    chk("k0_in_ready", 64'(bus_a.in_ready), 64'd1);
    bus_a.in_pc = 30'h21;
    tick();
    chk("k1_occ", 64'(bus_a.occupancy), 64'd2);
    chk("k1_in_ready", 64'(bus_a.in_ready), 64'd0);
    chk("k1_pc", 64'(bus_a.out_pc), 64'h20);
    bus_a.in_pc = 30'h22;  // offered while full: must not be taken
    tick();
    chk("k2_hold_pc", 64'(bus_a.out_pc), 64'h20);
    chk("k2_hold_occ", 64'(bus_a.occupancy), 64'd2);
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    tick();
    chk("k3_pc", 64'(bus_a.out_pc), 64'h21);
    chk("k3_occ", 64'(bus_a.occupancy), 64'd1);
    chk("k3_in_ready", 64'(bus_a.in_ready), 64'd1);
    tick();
    chk("k4_valid", 64'(bus_a.out_valid), 64'd0);
    chk("k4_occ", 64'(bus_a.occupancy), 64'd0);

    // ---------------- misalignment injection ------------------------------
    bus_a.out_ready = 1'b0; bus_a.in_valid = 1'b1; bus_a.miss_align = 1'b1;
    bus_a.in_pc = 30'h44; bus_a.in_en = 1'b1; bus_a.in_br_flag = 1'b1;
    bus_a.in_ctrl_op = 2'd2; bus_a.in_dst_addr = 5'd7; bus_a.in_gpr_we_ = 1'b0;
    bus_a.in_exp_code = 3'd2; bus_a.in_out = 32'hDEADBEEF;
    tick();
    chk("ma_pc", 64'(bus_a.out_pc), 64'h44);
    chk("ma_en", 64'(bus_a.out_en), 64'd1);
    chk("ma_br", 64'(bus_a.out_br_flag), 64'd1);
    chk("ma_ctrl", 64'(bus_a.out_ctrl_op), 64'd0);
    chk("ma_dst", 64'(bus_a.out_dst_addr), 64'd0);
    chk("ma_we_", 64'(bus_a.out_gpr_we_), 64'd1);
    chk("ma_exp", 64'(bus_a.out_exp_code), 64'd4);
    chk("ma_out", 64'(bus_a.out_out), 64'd0);

    // ---------------- flush while full with input offered -----------------
    bus_a.miss_align = 1'b0; bus_a.in_br_flag = 1'b0; bus_a.in_exp_code = 3'd0;
    bus_a.in_pc = 30'h31;
    tick();
    chk("fl_pre_occ", 64'(bus_a.occupancy), 64'd2);
    bus_a.flush = 1'b1; bus_a.in_pc = 30'h30;
    tick();
    chk("fl_valid", 64'(bus_a.out_valid), 64'd0);
    chk("fl_occ", 64'(bus_a.occupancy), 64'd0);
    chk("fl_in_ready", 64'(bus_a.in_ready), 64'd1);
    bus_a.flush = 1'b0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    tick();
    chk("fl_no_0x30_valid", 64'(bus_a.out_valid), 64'd0);
    chk("fl_no_0x30_pc", 64'(bus_a.out_pc), 64'd0);

    // ---------------- single register variant -----------------------------
    bus_b.in_valid = 1'b1; bus_b.in_pc = 30'h50; bus_b.out_ready = 1'b0;
    #1;
    chk("b_empty_in_ready", 64'(bus_b.in_ready), 64'd1);
    tick();
    chk("b0_pc", 64'(bus_b.out_pc), 64'h50);
    chk("b0_occ", 64'(bus_b.occupancy), 64'd1);
    chk("b0_in_ready", 64'(bus_b.in_ready), 64'd0);
    bus_b.in_pc = 30'h51;
    tick();
    chk("b1_hold_pc", 64'(bus_b.out_pc), 64'h50);
    bus_b.out_ready = 1'b1;
    #1;
    chk("b2_in_ready_comb", 64'(bus_b.in_ready), 64'd1);
    tick();
    chk("b2_reload_valid", 64'(bus_b.out_valid), 64'd1);
    chk("b2_reload_pc", 64'(bus_b.out_pc), 64'h51);
    bus_b.in_valid = 1'b0;
    tick();
    chk("b3_valid", 64'(bus_b.out_valid), 64'd0);
    chk("b3_occ", 64'(bus_b.occupancy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
